dual_port_ram_latency: RTL and testbench
========================================

DUAL_PORT_RAM_LATENCY -- requirements
Module: dual_port_ram_latency

Interface
REQ-001 Parameter DATA_WIDTH, default pkg DATA_WIDTH: data bits per word.
REQ-002 Parameter ADDRESS_WIDTH, default pkg ADDRESS_WIDTH: address bits; depth = 2**ADDRESS_WIDTH.
REQ-003 Parameter WRITE_LATENCY, default pkg WRITE_LATENCY: two-entry int array, index 0 = port A, 1 = port B, each >= 1.
REQ-004 Parameter READ_LATENCY, default pkg READ_LATENCY: two-entry int array, index 0 = port A, 1 = port B, each >= 1.
REQ-005 i_clk  input  1  single clock; all logic on its rising edge.
REQ-006 i_rst  input  1  synchronous, active-high reset.
REQ-007 i_addr_a / i_addr_b  input  ADDRESS_WIDTH  port request address.
REQ-008 i_en_a / i_en_b  input  1  port request enable; a request is captured at a rising edge with enable = 1.
REQ-009 i_we_a / i_we_b  input  1  1 = write request, 0 = read request.
REQ-010 i_din_a / i_din_b  input  DATA_WIDTH  write data.
REQ-011 o_dout_a / o_dout_b  output  DATA_WIDTH  registered read data.
REQ-012 o_valid_a / o_valid_b  output  1  one-cycle pulse; the port's o_dout holds new read data.

Function
REQ-013 Each port captures {addr, din, en, we} at every rising edge; the two ports are fully independent, with no back-pressure or stall.
REQ-014 Write path: a write captured at edge N commits to the array at edge N+WRITE_LATENCY-1, so latency 1 writes on the capture edge.
REQ-015 Read path: a read captured at edge N samples the array at edge N+READ_LATENCY-1; o_dout and o_valid update at that edge and are visible after it.
REQ-016 o_valid pulses high for exactly one cycle per read; back-to-back reads give back-to-back pulses, one per request, in order.
REQ-017 o_dout holds its last read value when no read completes; a write request never changes o_dout or o_valid.
REQ-018 Write-read same edge, same address, different ports: read-first, so the read returns the pre-write contents.
REQ-019 Write-read same edge, same address, same port: this cannot occur at latency-aligned edges; if the pipelines align, read-first applies.
REQ-020 Dual write collision (A and B commit to the same address on the same edge): port A data is stored and port B's write is dropped.
REQ-021 Writes to different addresses on the same edge both commit.
REQ-022 Address range wraps naturally; there is no out-of-range state.
REQ-023 The array holds no initial value until written; reads of unwritten locations return X in simulation.

Reset
REQ-024 While i_rst = 1: o_dout_a = o_dout_b = 0, o_valid_a = o_valid_b = 0, and all latency-pipeline stages are cleared to en = 0.
REQ-025 Reset mid-operation: requests in flight are discarded, with no later commit or read pulse.
REQ-026 Array contents are not cleared by reset; writes committed before reset persist.
REQ-027 A request presented on the first edge with i_rst = 0 is captured normally.

Structure
REQ-028 Shared package pkg holds DATA_WIDTH, ADDRESS_WIDTH, WRITE_LATENCY[2] and READ_LATENCY[2], and is shared with mem_intf and the bench.
REQ-029 The delay line is a sub-module latency_pipe, with a parameterized width and depth (depth = latency-1, 0 = pass-through) and synchronous clear; it is instantiated once per port per path (four instances).
REQ-030 The array is one shared two-write-port memory; the collision priority of REQ-020 is implemented explicitly, not left to simulator ordering.

Verification
(Parameters: DATA_WIDTH=8, ADDRESS_WIDTH=4, WRITE_LATENCY={2,3}, READ_LATENCY={1,2}.)
REQ-031 A writes 0xA5 to addr 3 at edge 0; B reads addr 3 at edge 0 and again at edge 1. Required: the edge-0 read returns old/X at edge 1 with o_valid_b; the edge-1 read returns 0xA5 at edge 2.
REQ-032 A writes 0x11 to addr 7 at edge 1 (commits edge 2); B writes 0x22 to addr 7 at edge 0 (commits edge 2); A reads addr 7 at edge 4. Required: o_dout_a = 0x11.
REQ-033 A reads addrs 0,1,2,3 on consecutive edges after preload 0x10..0x13. Required: o_valid_a is high for 4 consecutive cycles with 0x10, 0x11, 0x12, 0x13 in order.
REQ-034 B writes 0x5A to addr 9 at edge 0; i_rst = 1 at edge 1; read addr 9 after reset. Required: the old value is returned, not 0x5A, and o_dout/o_valid are 0 during reset.
REQ-035 Write 0x77 to addr 15, then reset, then read addr 15 on both ports at the same edge. Required: both return 0x77 at their respective latencies (A edge+0, B edge+1).

Source files
------------

// File: rtl/dual_port_ram_latency_pkg.sv
// -----------------------------------------------------------------------------
// dual_port_ram_latency_pkg
// Shared configuration for the dual-port latency RAM, its delay lines and the
// bench: word width, address width and the per-port write/read latencies
// (index 0 = port A, index 1 = port B).
// -----------------------------------------------------------------------------
package dual_port_ram_latency_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int ADDRESS_WIDTH = 4;

    localparam int WRITE_LATENCY [2] = '{2, 3};
    localparam int READ_LATENCY  [2] = '{1, 2};

    // A request captured at edge N acts at edge N+latency-1, so the delay line
    // in front of the array needs latency-1 register stages.
    function automatic int pipe_depth(input int latency);
        return (latency > 1) ? latency - 1 : 0;
    endfunction

endpackage

// File: rtl/dual_port_ram_latency_pipe.sv
// -----------------------------------------------------------------------------
// latency_pipe
// Fixed-depth delay line with synchronous clear. DEPTH = 0 is a plain wire.
// Ports:
//   clk_i  : clock, rising edge
//   clr_i  : synchronous clear, zeroes every stage (request flag = 0)
//   d_i    : word entering the line
//   q_o    : word leaving the line, DEPTH cycles later
// -----------------------------------------------------------------------------
module latency_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 0
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q_o = d_i;
            // Clock and clear have no job in a zero-stage line.
            logic unused_bypass;
            assign unused_bypass = clk_i ^ clr_i;
        end else begin : g_stages
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk_i) begin
                if (clr_i) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/dual_port_ram_latency.sv
// -----------------------------------------------------------------------------
// dual_port_ram_latency
// True dual-port RAM with independent, configurable write and read latency
// per port. Each port captures a request every rising edge; writes and reads
// travel through their own delay line before touching the shared array.
// Ports:
//   i_clk, i_rst              : clock and synchronous active-high reset
//   i_addr_x, i_en_x, i_we_x  : request address / enable / write select
//   i_din_x                   : write data
//   o_dout_x                  : registered read data (holds between reads)
//   o_valid_x                 : one-cycle pulse per completed read
// -----------------------------------------------------------------------------
module dual_port_ram_latency #(
    parameter int DATA_WIDTH        = dual_port_ram_latency_pkg::DATA_WIDTH,
    parameter int ADDRESS_WIDTH     = dual_port_ram_latency_pkg::ADDRESS_WIDTH,
    parameter int WRITE_LATENCY [2] = dual_port_ram_latency_pkg::WRITE_LATENCY,
    parameter int READ_LATENCY  [2] = dual_port_ram_latency_pkg::READ_LATENCY
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [ADDRESS_WIDTH-1:0] i_addr_a,
    input  logic [ADDRESS_WIDTH-1:0] i_addr_b,
    input  logic                     i_en_a,
    input  logic                     i_en_b,
    input  logic                     i_we_a,
    input  logic                     i_we_b,
    input  logic [DATA_WIDTH-1:0]    i_din_a,
    input  logic [DATA_WIDTH-1:0]    i_din_b,
    output logic [DATA_WIDTH-1:0]    o_dout_a,
    output logic [DATA_WIDTH-1:0]    o_dout_b,
    output logic                     o_valid_a,
    output logic                     o_valid_b
);

    import dual_port_ram_latency_pkg::*;

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    // Requests are decoded into write/read flags before entering the delay
    // lines so each line only carries the fields its path consumes.
    typedef struct packed {
        logic                     wr;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    data;
    } wr_req_t;

    typedef struct packed {
        logic                     rd;
        logic [ADDRESS_WIDTH-1:0] addr;
    } rd_req_t;

    wr_req_t wr_in [2];
    rd_req_t rd_in [2];

    assign wr_in[0] = '{wr: i_en_a & i_we_a,  addr: i_addr_a, data: i_din_a};
    assign wr_in[1] = '{wr: i_en_b & i_we_b,  addr: i_addr_b, data: i_din_b};
    assign rd_in[0] = '{rd: i_en_a & ~i_we_a, addr: i_addr_a};
    assign rd_in[1] = '{rd: i_en_b & ~i_we_b, addr: i_addr_b};

    // Shared array; no reset so it maps onto block RAM and survives i_rst.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            wr_req_t               wr_req;
            rd_req_t               rd_req;
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  valid_q;

            latency_pipe #(
                .WIDTH ($bits(wr_req_t)),
                .DEPTH (pipe_depth(WRITE_LATENCY[gi]))
            ) u_wr_pipe (
                .clk_i (i_clk),
                .clr_i (i_rst),
                .d_i   (wr_in[gi]),
                .q_o   (wr_req)
            );

            latency_pipe #(
                .WIDTH ($bits(rd_req_t)),
                .DEPTH (pipe_depth(READ_LATENCY[gi]))
            ) u_rd_pipe (
                .clk_i (i_clk),
                .clr_i (i_rst),
                .d_i   (rd_in[gi]),
                .q_o   (rd_req)
            );

            // Non-blocking read of mem_q gives read-first behaviour against
            // any write committing on the same edge, from either port.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_req.rd;
                    if (rd_req.rd) begin
                        dout_q <= mem_q[rd_req.addr];
                    end
                end
            end
        end
    endgenerate

    wr_req_t wr_a;
    wr_req_t wr_b;
    logic    commit_a;
    logic    commit_b;
    logic    b_shadowed;

    assign wr_a = g_port[0].wr_req;
    assign wr_b = g_port[1].wr_req;

    // A reset edge discards whatever reaches the array on that edge, including
    // zero-latency requests that bypass the cleared delay lines.
    assign commit_a   = ~i_rst & wr_a.wr;
    assign commit_b   = ~i_rst & wr_b.wr;
    // Port A wins a same-address collision; B's write is suppressed outright.
    assign b_shadowed = commit_a & (wr_a.addr == wr_b.addr);

    always_ff @(posedge i_clk) begin
        if (commit_a) begin
            mem_q[wr_a.addr] <= wr_a.data;
        end
        if (commit_b && !b_shadowed) begin
            mem_q[wr_b.addr] <= wr_b.data;
        end
    end

    assign o_dout_a  = g_port[0].dout_q;
    assign o_dout_b  = g_port[1].dout_q;
    assign o_valid_a = g_port[0].valid_q;
    assign o_valid_b = g_port[1].valid_q;

endmodule

// File: tb/tb_dual_port_ram_latency.sv
// -----------------------------------------------------------------------------
// tb_dual_port_ram_latency
// Directed bench with per-port scoreboards: every read request pushes its
// expected word; every o_valid pulse pops and compares. Between pulses the
// output must hold the last read word, and after a reset edge it must be 0.
// -----------------------------------------------------------------------------
module tb_dual_port_ram_latency;

    import dual_port_ram_latency_pkg::*;

    logic                     clk;
    logic                     rst;
    logic [ADDRESS_WIDTH-1:0] addr_a, addr_b;
    logic                     en_a, en_b;
    logic                     we_a, we_b;
    logic [DATA_WIDTH-1:0]    din_a, din_b;
    logic [DATA_WIDTH-1:0]    o_dout_a, o_dout_b;
    logic                     o_valid_a, o_valid_b;

    int checks   = 0;
    int failures = 0;

    logic [DATA_WIDTH-1:0] exp_a [$];
    logic [DATA_WIDTH-1:0] exp_b [$];
    logic [DATA_WIDTH-1:0] hold_a = '0;
    logic [DATA_WIDTH-1:0] hold_b = '0;
    logic                  rst_edge = 1'b1;

    dual_port_ram_latency dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_addr_a  (addr_a),
        .i_addr_b  (addr_b),
        .i_en_a    (en_a),
        .i_en_b    (en_b),
        .i_we_a    (we_a),
        .i_we_b    (we_b),
        .i_din_a   (din_a),
        .i_din_b   (din_b),
        .o_dout_a  (o_dout_a),
        .o_dout_b  (o_dout_b),
        .o_valid_a (o_valid_a),
        .o_valid_b (o_valid_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Whether the DUT's most recent edge was a reset edge.
    always @(posedge clk) rst_edge <= rst;

    // ---------------- output monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [DATA_WIDTH-1:0] want;
        // Port A
        if (rst_edge) begin
            checks++;
            assert (o_valid_a === 1'b0 && o_dout_a === '0) else begin
                failures++;
                $error("FAIL reset_a valid=%b dout=%h required valid=0 dout=00", o_valid_a, o_dout_a);
            end
            hold_a = '0;
        end else if (o_valid_a === 1'b1) begin
            checks++;
            assert (exp_a.size() != 0) else begin
                failures++;
                $error("FAIL extra_pulse_a valid=%b dout=%h required no pulse", o_valid_a, o_dout_a);
            end
            if (exp_a.size() != 0) begin
                want = exp_a.pop_front();
                checks++;
                assert (o_dout_a === want) else begin
                    failures++;
                    $error("FAIL read_a dout=%h required %h", o_dout_a, want);
                end
                $display("t=%0t port A read dout=%h expected=%h", $time, o_dout_a, want);
                hold_a = want;
            end
        end else begin
            checks++;
            assert (o_valid_a === 1'b0 && o_dout_a === hold_a) else begin
                failures++;
                $error("FAIL hold_a valid=%b dout=%h required valid=0 dout=%h", o_valid_a, o_dout_a, hold_a);
            end
        end
        // Port B
        if (rst_edge) begin
            checks++;
            assert (o_valid_b === 1'b0 && o_dout_b === '0) else begin
                failures++;
                $error("FAIL reset_b valid=%b dout=%h required valid=0 dout=00", o_valid_b, o_dout_b);
            end
            hold_b = '0;
        end else if (o_valid_b === 1'b1) begin
            checks++;
            assert (exp_b.size() != 0) else begin
                failures++;
                $error("FAIL extra_pulse_b valid=%b dout=%h required no pulse", o_valid_b, o_dout_b);
            end
            if (exp_b.size() != 0) begin
                want = exp_b.pop_front();
                checks++;
                assert (o_dout_b === want) else begin
                    failures++;
                    $error("FAIL read_b dout=%h required %h", o_dout_b, want);
                end
                $display("t=%0t port B read dout=%h expected=%h", $time, o_dout_b, want);
                hold_b = want;
            end
        end else begin
            checks++;
            assert (o_valid_b === 1'b0 && o_dout_b === hold_b) else begin
                failures++;
                $error("FAIL hold_b valid=%b dout=%h required valid=0 dout=%h", o_valid_b, o_dout_b, hold_b);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr_a(input logic [ADDRESS_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
        en_a = 1'b1; we_a = 1'b1; addr_a = a; din_a = d;
    endtask

    task automatic wr_b(input logic [ADDRESS_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
        en_b = 1'b1; we_b = 1'b1; addr_b = a; din_b = d;
    endtask

    task automatic rd_a(input logic [ADDRESS_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] want);
        en_a = 1'b1; we_a = 1'b0; addr_a = a;
        exp_a.push_back(want);
    endtask

    task automatic rd_b(input logic [ADDRESS_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] want);
        en_b = 1'b1; we_b = 1'b0; addr_b = a;
        exp_b.push_back(want);
    endtask

    // One rising edge captures whatever is driven; requests are single-cycle.
    task automatic step();
        @(posedge clk);
        #1;
        en_a = 1'b0; we_a = 1'b0;
        en_b = 1'b0; we_b = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        en_a = 1'b0; we_a = 1'b0; addr_a = '0; din_a = '0;
        en_b = 1'b0; we_b = 1'b0; addr_b = '0; din_b = '0;
        idle(3);
        rst = 1'b0;

        // Preload through port A, starting on the first edge out of reset.
        wr_a(4'd0,  8'h10); step();
        wr_a(4'd1,  8'h11); step();
        wr_a(4'd2,  8'h12); step();
        wr_a(4'd3,  8'h13); step();
        wr_a(4'd15, 8'h77); step();
        wr_a(4'd9,  8'h99); step();
        wr_a(4'd10, 8'h0A); step();
        idle(2);

        // Back-to-back reads on A: four consecutive pulses in order.
        rd_a(4'd0, 8'h10); step();
        rd_a(4'd1, 8'h11); step();
        rd_a(4'd2, 8'h12); step();
        rd_a(4'd3, 8'h13); step();
        idle(2);

        // A writes addr 3 (commits next edge) while B reads it: read-first.
        wr_a(4'd3, 8'hA5); rd_b(4'd3, 8'h13); step();
        rd_b(4'd3, 8'hA5); step();
        idle(3);

        // Both ports commit to addr 7 on the same edge: A wins.
        wr_b(4'd7, 8'h22); step();
        wr_a(4'd7, 8'h11); step();
        idle(2);
        rd_a(4'd7, 8'h11); step();
        idle(2);
        rd_b(4'd7, 8'h11); step();
        idle(2);

        // Writes to different addresses both land.
        wr_a(4'd5, 8'h55); wr_b(4'd6, 8'h66); step();
        idle(3);
        rd_a(4'd6, 8'h66); rd_b(4'd5, 8'h55); step();
        idle(3);

        // Writes in flight when reset arrives must never commit; a read
        // presented during reset must never pulse.
        wr_a(4'd10, 8'hAA); wr_b(4'd9, 8'h5A); step();
        rst = 1'b1;
        en_b = 1'b1; we_b = 1'b0; addr_b = 4'd9;
        step();
        step();
        rst = 1'b0;

        // Array contents persist across reset.
        rd_a(4'd15, 8'h77); rd_b(4'd15, 8'h77); step();
        rd_a(4'd9,  8'h99); rd_b(4'd10, 8'h0A); step();
        rd_a(4'd10, 8'h0A); rd_b(4'd9,  8'h99); step();
        idle(5);

        checks++;
        assert (exp_a.size() == 0) else begin
            failures++;
            $error("FAIL missing_pulses_a pending=%0d required 0", exp_a.size());
        end
        checks++;
        assert (exp_b.size() == 0) else begin
            failures++;
            $error("FAIL missing_pulses_b pending=%0d required 0", exp_b.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
